// File: rtl/rv32i_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_seq_ctrl_pkg
// Shared definitions for the multi-cycle RV32I sequencer: the sequencer state
// encoding, trap cause codes, the NOP instruction used as the reset value of
// the instruction latch, and the bus watchdog counter width.
// No ports (package).
// ---------------------------------------------------------------------------
package rv32i_seq_ctrl_pkg;

    // Sequencer states, 3-bit encoding
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_e;

    // Trap cause codes reported on trap_cause
    localparam logic [1:0] TRAP_NONE = 2'b00;
    localparam logic [1:0] TRAP_ILL  = 2'b01;
    localparam logic [1:0] TRAP_BUS  = 2'b10;
    localparam logic [1:0] TRAP_MIS  = 2'b11;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // Wide enough for a watchdog limit of up to 255 cycles
    localparam int WDOG_W = 8;

    // A jump target is misaligned when it is not on a 4-byte boundary
    function automatic logic is_misaligned(input logic [1:0] addr_lo);
        return addr_lo != 2'b00;
    endfunction

endpackage

// File: rtl/rv32i_seq_ctrl_bus_wdog.sv
// ---------------------------------------------------------------------------
// bus_wdog
// Counts the cycles a memory request has been outstanding without an ack and
// flags expiry in the cycle the count would reach BUS_TIMEOUT.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart the count (asserted when a new request phase begins)
//   req        : a request is outstanding this cycle
//   ack        : the outstanding request completes this cycle
//   expired    : this is the BUS_TIMEOUT-th request cycle and no ack arrived
// ---------------------------------------------------------------------------
module bus_wdog
    import rv32i_seq_ctrl_pkg::*;
#(
    parameter int BUS_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic req,
    input  logic ack,
    output logic expired
);

    localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(BUS_TIMEOUT - 1);

    logic [WDOG_W-1:0] count_q;
    logic [WDOG_W-1:0] count_d;

    // Count request cycles that end without an ack. An ack in the final
    // allowed cycle suppresses expiry, so the ack always wins the race.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (req && !ack) begin
            count_d = count_q + WDOG_W'(1);
        end
        expired = req && !ack && (count_q == LIMIT);
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/rv32i_seq_ctrl.sv
// ---------------------------------------------------------------------------
// rv32i_seq_ctrl
// Multi-cycle sequencer for the RV32I core: IDLE -> FETCH -> DECODE -> EXEC
// -> [MEM] -> WB, with a terminal TRAP state left only through reset. Owns the
// PC and the latched instruction, handshakes the instruction and data memory
// ports, and produces registered single-cycle register-file/retire strobes.
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   run                      : start/continue, sampled in IDLE and in WB
//   imem_req/addr/ack/rdata  : instruction fetch port
//   inst, pc                 : latched instruction and its address
//   dec_*                    : decoder results for the latched instruction
//   alu_br_taken, alu_target : branch outcome and redirect target
//   dmem_req/we/ack          : data access port
//   rf_we, retire            : single-cycle write-back strobes
//   trap, trap_cause         : sticky trap flag and first cause
// ---------------------------------------------------------------------------
module rv32i_seq_ctrl
    import rv32i_seq_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BUS_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] pc,
    input  logic        dec_illegal,
    input  logic        dec_mem_ren,
    input  logic        dec_mem_wen,
    input  logic        dec_rf_wen,
    input  logic        dec_jump,
    input  logic        alu_br_taken,
    input  logic [31:0] alu_target,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        rf_we,
    output logic        retire,
    output logic        trap,
    output logic [1:0]  trap_cause
);

    state_e      state_q,      state_d;
    logic [31:0] pc_q,         pc_d;
    logic [31:0] inst_q,       inst_d;
    logic [31:0] target_q,     target_d;
    logic        redirect_q,   redirect_d;
    logic        imem_req_q,   imem_req_d;
    logic        dmem_req_q,   dmem_req_d;
    logic        dmem_we_q,    dmem_we_d;
    logic        rf_we_q,      rf_we_d;
    logic        retire_q,     retire_d;
    logic        trap_q,       trap_d;
    logic [1:0]  trap_cause_q, trap_cause_d;

    logic        wdog_clr;
    logic        wdog_req;
    logic        wdog_ack;
    logic        wdog_expired;

    // Acks only count while the matching request is actually outstanding
    assign wdog_req = imem_req_q | dmem_req_q;
    assign wdog_ack = (imem_req_q & imem_ack) | (dmem_req_q & dmem_ack);

    bus_wdog #(
        .BUS_TIMEOUT(BUS_TIMEOUT)
    ) u_bus_wdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (wdog_clr),
        .req    (wdog_req),
        .ack    (wdog_ack),
        .expired(wdog_expired)
    );

    // Next-state logic. Redirect decision and target are captured in EXEC so
    // WB can update the PC even though the ALU has moved on. All strobes are
    // derived from the next state, so they come straight out of flops.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        target_d     = target_q;
        redirect_d   = redirect_q;
        dmem_we_d    = dmem_we_q;
        trap_cause_d = trap_cause_q;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem_ack) begin
                    inst_d  = imem_rdata;
                    state_d = S_DECODE;
                end else if (wdog_expired) begin
                    state_d      = S_TRAP;
                    trap_cause_d = TRAP_BUS;
                end
            end
            S_DECODE: begin
                if (dec_illegal) begin
                    state_d      = S_TRAP;
                    trap_cause_d = TRAP_ILL;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                redirect_d = dec_jump | alu_br_taken;
                target_d   = alu_target;
                if (redirect_d && is_misaligned(alu_target[1:0])) begin
                    state_d      = S_TRAP;
                    trap_cause_d = TRAP_MIS;
                end else if (dec_mem_ren || dec_mem_wen) begin
                    state_d   = S_MEM;
                    dmem_we_d = dec_mem_wen;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (dmem_ack) begin
                    state_d = S_WB;
                end else if (wdog_expired) begin
                    state_d      = S_TRAP;
                    trap_cause_d = TRAP_BUS;
                end
            end
            S_WB: begin
                pc_d    = redirect_q ? target_q : pc_q + 32'd4;
                state_d = run ? S_FETCH : S_IDLE;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d != S_MEM) begin
            dmem_we_d = 1'b0;
        end

        imem_req_d = (state_d == S_FETCH);
        dmem_req_d = (state_d == S_MEM);
        retire_d   = (state_d == S_WB);
        rf_we_d    = (state_d == S_WB) && dec_rf_wen;
        trap_d     = (state_d == S_TRAP);

        // Restart the watchdog whenever a fresh request phase begins
        wdog_clr = (state_d != state_q) &&
                   ((state_d == S_FETCH) || (state_d == S_MEM));
    end

    // Sequencer state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            inst_q       <= NOP_INST;
            target_q     <= '0;
            redirect_q   <= 1'b0;
            imem_req_q   <= 1'b0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            rf_we_q      <= 1'b0;
            retire_q     <= 1'b0;
            trap_q       <= 1'b0;
            trap_cause_q <= TRAP_NONE;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            target_q     <= target_d;
            redirect_q   <= redirect_d;
            imem_req_q   <= imem_req_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            rf_we_q      <= rf_we_d;
            retire_q     <= retire_d;
            trap_q       <= trap_d;
            trap_cause_q <= trap_cause_d;
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = pc_q;
    assign inst       = inst_q;
    assign pc         = pc_q;
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign rf_we      = rf_we_q;
    assign retire     = retire_q;
    assign trap       = trap_q;
    assign trap_cause = trap_cause_q;

endmodule

// File: tb/tb_rv32i_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rv32i_seq_ctrl
// Directed self-checking bench for rv32i_seq_ctrl with BUS_TIMEOUT=4.
// The bench plays the roles of instruction memory, data memory, decoder and
// ALU; every expected value below is worked out by hand from the sequencer's
// state-by-state behaviour.
// ---------------------------------------------------------------------------
module tb_rv32i_seq_ctrl;

    localparam logic [31:0] ADDI = 32'h0050_0093;
    localparam logic [31:0] LW   = 32'h0000_2103;
    localparam logic [31:0] SW   = 32'h0020_2023;
    localparam logic [31:0] BEQ  = 32'h0200_0063;
    localparam logic [31:0] JAL  = 32'h0000_006F;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        dec_illegal;
    logic        dec_mem_ren;
    logic        dec_mem_wen;
    logic        dec_rf_wen;
    logic        dec_jump;
    logic        alu_br_taken;
    logic [31:0] alu_target;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    logic        rf_we;
    logic        retire;
    logic        trap;
    logic [1:0]  trap_cause;

    int compareCount  = 0;
    int mismatchCount = 0;
    int cycleCount    = 0;
    int startCycle    = 0;

    rv32i_seq_ctrl #(
        .RESET_PC   (32'h0000_0000),
        .BUS_TIMEOUT(4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .inst        (inst),
        .pc          (pc),
        .dec_illegal (dec_illegal),
        .dec_mem_ren (dec_mem_ren),
        .dec_mem_wen (dec_mem_wen),
        .dec_rf_wen  (dec_rf_wen),
        .dec_jump    (dec_jump),
        .alu_br_taken(alu_br_taken),
        .alu_target  (alu_target),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_ack    (dmem_ack),
        .rf_we       (rf_we),
        .retire      (retire),
        .trap        (trap),
        .trap_cause  (trap_cause)
    );

    // 10 ns core clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its hand-computed expectation
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Drive the decoder/ALU view of the current instruction
    task automatic applyStimulus(input logic illegal, input logic ren, input logic wen,
                                 input logic rfw, input logic jump, input logic br,
                                 input logic [31:0] target);
        dec_illegal  = illegal;
        dec_mem_ren  = ren;
        dec_mem_wen  = wen;
        dec_rf_wen   = rfw;
        dec_jump     = jump;
        alu_br_taken = br;
        alu_target   = target;
    endtask

    // Advance one clock and settle just after the edge
    task automatic waitCycle();
        @(posedge clk);
        #1;
        cycleCount++;
    endtask

    // Zero-wait fetch: answer the pending request in its first cycle
    task automatic fetchWord(input logic [31:0] word);
        checkOutput("fetch_req", {31'd0, imem_req}, 32'd1);
        imem_ack   = 1'b1;
        imem_rdata = word;
        waitCycle();
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        checkOutput("fetch_inst", inst, word);
    endtask

    // Asynchronous reset pulse placed between clock edges
    task automatic pulseReset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_trap", {31'd0, trap}, 32'd0);
        checkOutput("rst_cause", {30'd0, trap_cause}, 32'd0);
        checkOutput("rst_pc", pc, 32'h0);
        checkOutput("rst_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        run        = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        dmem_ack   = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        // Reset values
        #12;
        checkOutput("reset_pc", pc, 32'h0);
        checkOutput("reset_inst", inst, NOP);
        checkOutput("reset_imem_req", {31'd0, imem_req}, 32'd0);
        checkOutput("reset_dmem_req", {31'd0, dmem_req}, 32'd0);
        checkOutput("reset_rf_we", {31'd0, rf_we}, 32'd0);
        checkOutput("reset_retire", {31'd0, retire}, 32'd0);
        checkOutput("reset_trap", {31'd0, trap}, 32'd0);
        checkOutput("reset_cause", {30'd0, trap_cause}, 32'd0);
        rst_n = 1'b1;
        waitCycle();
        checkOutput("idle_no_req", {31'd0, imem_req}, 32'd0);

        // ADDI, zero wait: FETCH, DECODE, EXEC, WB
        $display("[TB] ALU instruction");
        run = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        waitCycle();
        startCycle = cycleCount;
        checkOutput("alu_addr", imem_addr, 32'h0);
        fetchWord(ADDI);
        waitCycle();
        checkOutput("alu_rfwe_exec", {31'd0, rf_we}, 32'd0);
        waitCycle();
        checkOutput("alu_rfwe_wb", {31'd0, rf_we}, 32'd1);
        checkOutput("alu_retire", {31'd0, retire}, 32'd1);
        checkOutput("alu_cycles", cycleCount - startCycle + 1, 32'd4);
        waitCycle();
        checkOutput("alu_rfwe_after", {31'd0, rf_we}, 32'd0);
        checkOutput("alu_retire_after", {31'd0, retire}, 32'd0);
        checkOutput("alu_pc", pc, 32'h4);
        checkOutput("alu_next_addr", imem_addr, 32'h4);

        // Load with dmem_ack in the 4th request cycle (the watchdog limit)
        $display("[TB] load with wait states");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        startCycle = cycleCount;
        fetchWord(LW);
        waitCycle();
        waitCycle();
        for (int i = 0; i < 4; i++) begin
            checkOutput("ld_dmem_req", {31'd0, dmem_req}, 32'd1);
            checkOutput("ld_dmem_we", {31'd0, dmem_we}, 32'd0);
            if (i == 3) dmem_ack = 1'b1;
            waitCycle();
        end
        dmem_ack = 1'b0;
        checkOutput("ld_req_dropped", {31'd0, dmem_req}, 32'd0);
        checkOutput("ld_rf_we", {31'd0, rf_we}, 32'd1);
        checkOutput("ld_retire", {31'd0, retire}, 32'd1);
        checkOutput("ld_trap", {31'd0, trap}, 32'd0);
        checkOutput("ld_cycles", cycleCount - startCycle + 1, 32'd8);
        waitCycle();
        checkOutput("ld_pc", pc, 32'h8);

        // Taken branch to 0x40
        $display("[TB] branches and jumps");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40);
        fetchWord(BEQ);
        waitCycle();
        waitCycle();
        checkOutput("br_rf_we", {31'd0, rf_we}, 32'd0);
        checkOutput("br_retire", {31'd0, retire}, 32'd1);
        waitCycle();
        checkOutput("br_pc", pc, 32'h40);
        checkOutput("br_addr", imem_addr, 32'h40);

        // JAL to the last word of the address space
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC);
        fetchWord(JAL);
        waitCycle();
        waitCycle();
        checkOutput("jal_rf_we", {31'd0, rf_we}, 32'd1);
        waitCycle();
        checkOutput("jal_pc", pc, 32'hFFFF_FFFC);

        // Not-taken with a misaligned target: no trap, pc wraps to 0
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_1235);
        fetchWord(ADDI);
        waitCycle();
        waitCycle();
        waitCycle();
        checkOutput("wrap_pc", pc, 32'h0);
        checkOutput("wrap_trap", {31'd0, trap}, 32'd0);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        fetchWord(ADDI);
        waitCycle();
        waitCycle();
        waitCycle();
        checkOutput("pc_after_wrap", pc, 32'h4);

        // Taken branch to a misaligned target
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h42);
        fetchWord(BEQ);
        waitCycle();
        waitCycle();
        checkOutput("mis_trap", {31'd0, trap}, 32'd1);
        checkOutput("mis_cause", {30'd0, trap_cause}, 32'd3);
        checkOutput("mis_pc", pc, 32'h4);
        checkOutput("mis_retire", {31'd0, retire}, 32'd0);
        checkOutput("mis_imem_req", {31'd0, imem_req}, 32'd0);
        waitCycle();
        waitCycle();
        checkOutput("mis_pc_frozen", pc, 32'h4);
        run = 1'b0;
        pulseReset();

        // Illegal instruction: trap after DECODE, immune to acks and run
        $display("[TB] illegal instruction");
        run = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        waitCycle();
        fetchWord(32'hFFFF_FFFF);
        waitCycle();
        checkOutput("ill_trap", {31'd0, trap}, 32'd1);
        checkOutput("ill_cause", {30'd0, trap_cause}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            run      = ~run;
            imem_ack = 1'b1;
            dmem_ack = 1'b1;
            waitCycle();
            checkOutput("ill_sticky_trap", {31'd0, trap}, 32'd1);
            checkOutput("ill_sticky_cause", {30'd0, trap_cause}, 32'd1);
            checkOutput("ill_no_req", {31'd0, imem_req}, 32'd0);
            checkOutput("ill_no_retire", {31'd0, retire}, 32'd0);
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        run      = 1'b0;
        pulseReset();

        // Fetch never acked: 4 request cycles then a bus trap
        $display("[TB] bus timeout");
        run = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        waitCycle();
        for (int i = 0; i < 4; i++) begin
            checkOutput("to_imem_req", {31'd0, imem_req}, 32'd1);
            waitCycle();
        end
        checkOutput("to_trap", {31'd0, trap}, 32'd1);
        checkOutput("to_cause", {30'd0, trap_cause}, 32'd2);
        checkOutput("to_req_dropped", {31'd0, imem_req}, 32'd0);
        run = 1'b0;
        pulseReset();

        // Ack exactly on the 4th request cycle wins over the timeout
        run = 1'b1;
        waitCycle();
        for (int i = 0; i < 4; i++) begin
            checkOutput("lim_imem_req", {31'd0, imem_req}, 32'd1);
            if (i == 3) begin
                imem_ack   = 1'b1;
                imem_rdata = ADDI;
            end
            waitCycle();
        end
        imem_ack = 1'b0;
        checkOutput("lim_no_trap", {31'd0, trap}, 32'd0);
        checkOutput("lim_inst", inst, ADDI);
        waitCycle();
        waitCycle();
        checkOutput("lim_retire", {31'd0, retire}, 32'd1);
        waitCycle();
        checkOutput("lim_pc", pc, 32'h4);

        // Store (load flag also set) with run dropped during MEM
        $display("[TB] store, run drop and mid-fetch reset");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        fetchWord(SW);
        waitCycle();
        waitCycle();
        checkOutput("st_dmem_req", {31'd0, dmem_req}, 32'd1);
        checkOutput("st_dmem_we", {31'd0, dmem_we}, 32'd1);
        run = 1'b0;
        waitCycle();
        checkOutput("st_dmem_req_held", {31'd0, dmem_req}, 32'd1);
        dmem_ack = 1'b1;
        waitCycle();
        dmem_ack = 1'b0;
        checkOutput("st_retire", {31'd0, retire}, 32'd1);
        checkOutput("st_rf_we", {31'd0, rf_we}, 32'd0);
        checkOutput("st_req_dropped", {31'd0, dmem_req}, 32'd0);
        waitCycle();
        checkOutput("st_idle_retire", {31'd0, retire}, 32'd0);
        checkOutput("st_idle_req", {31'd0, imem_req}, 32'd0);
        checkOutput("st_pc", pc, 32'h8);
        waitCycle();
        checkOutput("st_still_idle", {31'd0, imem_req}, 32'd0);
        run = 1'b1;
        waitCycle();
        checkOutput("resume_req", {31'd0, imem_req}, 32'd1);
        checkOutput("resume_addr", imem_addr, 32'h8);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_req", {31'd0, imem_req}, 32'd0);
        checkOutput("async_pc", pc, 32'h0);
        checkOutput("async_inst", inst, NOP);
        checkOutput("async_trap", {31'd0, trap}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        waitCycle();
        checkOutput("after_rst_req", {31'd0, imem_req}, 32'd1);
        checkOutput("after_rst_addr", imem_addr, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
